// File: rtl/alu_reg.sv
// ----------------------------------------------------------------------------
// alu_reg -- registered WIDTH-bit ALU
//
// Computes one of eight operations on A/B every cycle and registers the
// result together with its flags. One cycle of latency, no enable, no
// handshake: a new operation may be issued on every clock.
//
// Optional feature macro: ALU_FLAGS_EN
//   When defined, the zero and overflow ports and their logic are present.
//
// Parameters
//   WIDTH      operand/result width in bits (2..32), default 4
//
// Ports
//   clk        sole clock, rising-edge
//   rst        asynchronous, active-high reset; clears every output
//   A, B       operands (B ignored by NOT and the shifts)
//   sel        operation select:
//                000 ADD  001 SUB  010 AND  011 OR
//                100 NOT  101 XOR  110 SHL  111 SHR
//   result     registered result
//   carry_out  registered carry (ADD), borrow (SUB) or shifted-out bit
//   zero       registered (result == 0)               [ALU_FLAGS_EN only]
//   overflow   registered signed overflow, ADD/SUB    [ALU_FLAGS_EN only]
// ----------------------------------------------------------------------------
module alu_reg #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       sel,
    output logic [WIDTH-1:0] result,
    output logic             carry_out
`ifdef ALU_FLAGS_EN
    ,
    output logic             zero,
    output logic             overflow
`endif
);

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [2:0] OpAnd = 3'b010;
    localparam logic [2:0] OpOr  = 3'b011;
    localparam logic [2:0] OpNot = 3'b100;
    localparam logic [2:0] OpXor = 3'b101;
    localparam logic [2:0] OpShl = 3'b110;
    localparam logic [2:0] OpShr = 3'b111;

    // Widened by one bit so the MSB is the carry (ADD) or borrow (SUB).
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] result_d;
    logic             carry_d;

    assign sum  = {1'b0, A} + {1'b0, B};
    assign diff = {1'b0, A} - {1'b0, B};

    always_comb begin
        result_d = '0;
        carry_d  = 1'b0;
        unique case (sel)
            OpAdd: begin
                result_d = sum[WIDTH-1:0];
                carry_d  = sum[WIDTH];
            end
            OpSub: begin
                result_d = diff[WIDTH-1:0];
                carry_d  = diff[WIDTH];
            end
            OpAnd: result_d = A & B;
            OpOr:  result_d = A | B;
            OpNot: result_d = ~A;
            OpXor: result_d = A ^ B;
            OpShl: begin
                result_d = A << 1;
                carry_d  = A[WIDTH-1];
            end
            OpShr: begin
                result_d = A >> 1;
                carry_d  = A[0];
            end
            default: begin
                result_d = '0;
                carry_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result    <= '0;
            carry_out <= 1'b0;
        end else begin
            result    <= result_d;
            carry_out <= carry_d;
        end
    end

`ifdef ALU_FLAGS_EN
    logic overflow_d;

    // Signed overflow: ADD when like-signed operands give a differently
    // signed sum; SUB when unlike-signed operands give a result whose sign
    // differs from A.
    always_comb begin
        overflow_d = 1'b0;
        if (sel == OpAdd) begin
            overflow_d = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
        end else if (sel == OpSub) begin
            overflow_d = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            zero     <= (result_d == '0);
            overflow <= overflow_d;
        end
    end
`endif

endmodule

// File: tb/tb_alu_reg.sv
// ----------------------------------------------------------------------------
// tb_alu_reg -- directed self-checking bench for alu_reg (WIDTH=4).
// Operands are driven on the falling edge; outputs are sampled 1 time unit
// after the following rising edge. Flag checks exist only when the bench is
// built with ALU_FLAGS_EN.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_reg;

    localparam int unsigned W = 4;

    logic         clk;
    logic         rst;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [2:0]   sel;
    logic [W-1:0] result;
    logic         carry_out;
`ifdef ALU_FLAGS_EN
    logic         zero;
    logic         overflow;
`endif

    int tests;
    int fails;

    alu_reg #(
        .WIDTH(W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .A        (A),
        .B        (B),
        .sel      (sel),
        .result   (result),
        .carry_out(carry_out)
`ifdef ALU_FLAGS_EN
        ,
        .zero     (zero),
        .overflow (overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive on the falling edge, then land just after the next rising edge.
    task automatic apply(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] s);
        @(negedge clk);
        A   = a;
        B   = b;
        sel = s;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        // rst is high from time zero; NOT of 0000 would give 1111 if captured.
        #1;
        tests++;
        if (result !== 4'b0000 || carry_out !== 1'b0) begin
            fails++;
            $display("FAIL reset_initial: result=%b carry=%b expected result=0000 carry=0",
                     result, carry_out);
        end
`ifdef ALU_FLAGS_EN
        tests++;
        if (zero !== 1'b0 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL reset_flags: zero=%b overflow=%b expected 0 0", zero, overflow);
        end
`endif
        apply(4'b0000, 4'b0000, 3'b100);
        apply(4'b1110, 4'b0000, 3'b110);
        tests++;
        if (result !== 4'b0000 || carry_out !== 1'b0) begin
            fails++;
            $display("FAIL reset_hold: result=%b carry=%b expected result=0000 carry=0",
                     result, carry_out);
        end
        // First edge after release captures current inputs.
        @(negedge clk);
        rst = 1'b0;
        A   = 4'b1101;
        sel = 3'b100;
        @(posedge clk);
        #1;
        tests++;
        if (result !== 4'b0010 || carry_out !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: result=%b carry=%b expected result=0010 carry=0",
                     result, carry_out);
        end
    endtask

    task automatic test_add();
        apply(4'b0101, 4'b0011, 3'b000);
        tests++;
        if (result !== 4'b1000 || carry_out !== 1'b0) begin
            fails++;
            $display("FAIL add_basic: result=%b carry=%b expected result=1000 carry=0",
                     result, carry_out);
        end
        apply(4'b1111, 4'b0001, 3'b000);
        tests++;
        if (result !== 4'b0000 || carry_out !== 1'b1) begin
            fails++;
            $display("FAIL add_wrap: result=%b carry=%b expected result=0000 carry=1",
                     result, carry_out);
        end
    endtask

    task automatic test_sub();
        apply(4'b1001, 4'b0011, 3'b001);
        tests++;
        if (result !== 4'b0110 || carry_out !== 1'b0) begin
            fails++;
            $display("FAIL sub_basic: result=%b carry=%b expected result=0110 carry=0",
                     result, carry_out);
        end
        apply(4'b0000, 4'b0001, 3'b001);
        tests++;
        if (result !== 4'b1111 || carry_out !== 1'b1) begin
            fails++;
            $display("FAIL sub_borrow: result=%b carry=%b expected result=1111 carry=1",
                     result, carry_out);
        end
    endtask

    task automatic test_logic();
        // Preceded by a borrow, so a stale carry would show up here.
        logic [W-1:0] va [4];
        logic [W-1:0] vb [4];
        logic [2:0]   vs [4];
        logic [W-1:0] ve [4];
        va = '{4'b1010, 4'b1010, 4'b1101, 4'b1010};
        vb = '{4'b1100, 4'b0101, 4'b0110, 4'b0110};
        vs = '{3'b010,  3'b011,  3'b100,  3'b101};
        ve = '{4'b1000, 4'b1111, 4'b0010, 4'b1100};
        for (int i = 0; i < 4; i++) begin
            apply(va[i], vb[i], vs[i]);
            tests++;
            if (result !== ve[i] || carry_out !== 1'b0) begin
                fails++;
                $display("FAIL logic_op sel=%b: result=%b carry=%b expected result=%b carry=0",
                         vs[i], result, carry_out, ve[i]);
            end
        end
    endtask

    task automatic test_shift();
        apply(4'b1011, 4'b0000, 3'b110);
        tests++;
        if (result !== 4'b0110 || carry_out !== 1'b1) begin
            fails++;
            $display("FAIL shl: result=%b carry=%b expected result=0110 carry=1",
                     result, carry_out);
        end
        apply(4'b1011, 4'b0000, 3'b111);
        tests++;
        if (result !== 4'b0101 || carry_out !== 1'b1) begin
            fails++;
            $display("FAIL shr: result=%b carry=%b expected result=0101 carry=1",
                     result, carry_out);
        end
        apply(4'b0110, 4'b0000, 3'b111);
        tests++;
        if (result !== 4'b0011 || carry_out !== 1'b0) begin
            fails++;
            $display("FAIL shr_nocarry: result=%b carry=%b expected result=0011 carry=0",
                     result, carry_out);
        end
        apply(4'b0101, 4'b1111, 3'b110);
        tests++;
        if (result !== 4'b1010 || carry_out !== 1'b0) begin
            fails++;
            $display("FAIL shl_nocarry: result=%b carry=%b expected result=1010 carry=0",
                     result, carry_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] va [5];
        logic [W-1:0] vb [5];
        logic [2:0]   vs [5];
        logic [W-1:0] ve [5];
        logic         vc [5];
        va = '{4'b0001, 4'b0010, 4'b1111, 4'b1001, 4'b0110};
        vb = '{4'b0010, 4'b0011, 4'b0101, 4'b0000, 4'b0000};
        vs = '{3'b000,  3'b001,  3'b101,  3'b110,  3'b111};
        ve = '{4'b0011, 4'b1111, 4'b1010, 4'b0010, 4'b0011};
        vc = '{1'b0,    1'b1,    1'b0,    1'b1,    1'b0};
        for (int i = 0; i < 5; i++) begin
            apply(va[i], vb[i], vs[i]);
            tests++;
            if (result !== ve[i] || carry_out !== vc[i]) begin
                fails++;
                $display("FAIL b2b step %0d: result=%b carry=%b expected result=%b carry=%b",
                         i, result, carry_out, ve[i], vc[i]);
            end
        end
        // With no new edge, the output must hold.
        @(negedge clk);
        A   = 4'b0000;
        sel = 3'b100;
        #2;
        tests++;
        if (result !== 4'b0011 || carry_out !== 1'b0) begin
            fails++;
            $display("FAIL hold_between_edges: result=%b carry=%b expected result=0011 carry=0",
                     result, carry_out);
        end
    endtask

    task automatic test_reset_mid_stream();
        apply(4'b0101, 4'b0011, 3'b000);
        @(negedge clk);
        A   = 4'b1111;
        B   = 4'b0001;
        sel = 3'b000;
        rst = 1'b1;
        #1;
        tests++;
        if (result !== 4'b0000 || carry_out !== 1'b0) begin
            fails++;
            $display("FAIL reset_async: result=%b carry=%b expected result=0000 carry=0",
                     result, carry_out);
        end
        @(posedge clk);
        #1;
        tests++;
        if (result !== 4'b0000 || carry_out !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_hold: result=%b carry=%b expected result=0000 carry=0",
                     result, carry_out);
        end
        @(negedge clk);
        rst = 1'b0;
        A   = 4'b0101;
        B   = 4'b0011;
        @(posedge clk);
        #1;
        tests++;
        if (result !== 4'b1000 || carry_out !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_release: result=%b carry=%b expected result=1000 carry=0",
                     result, carry_out);
        end
    endtask

`ifdef ALU_FLAGS_EN
    task automatic test_flags();
        logic [W-1:0] va [5];
        logic [W-1:0] vb [5];
        logic [2:0]   vs [5];
        logic         vz [5];
        logic         vo [5];
        // 0111+0001 ovf; 1010&0101 zero; 1000-0001 ovf; 0011-0011 zero;
        // 1111+1111 carry but no signed overflow.
        va = '{4'b0111, 4'b1010, 4'b1000, 4'b0011, 4'b1111};
        vb = '{4'b0001, 4'b0101, 4'b0001, 4'b0011, 4'b1111};
        vs = '{3'b000,  3'b010,  3'b001,  3'b001,  3'b000};
        vz = '{1'b0,    1'b1,    1'b0,    1'b1,    1'b0};
        vo = '{1'b1,    1'b0,    1'b1,    1'b0,    1'b0};
        for (int i = 0; i < 5; i++) begin
            apply(va[i], vb[i], vs[i]);
            tests++;
            if (zero !== vz[i] || overflow !== vo[i]) begin
                fails++;
                $display("FAIL flags step %0d: zero=%b overflow=%b expected zero=%b overflow=%b",
                         i, zero, overflow, vz[i], vo[i]);
            end
        end
    endtask
`endif

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        A     = '0;
        B     = '0;
        sel   = 3'b000;
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_shift();
        test_back_to_back();
        test_reset_mid_stream();
`ifdef ALU_FLAGS_EN
        test_flags();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
